// File: rtl/serdes_tx_link_ctrl_if.sv
// Word bus between user fabric logic and the transmit link controller.
// The controller owns in_ready and the outgoing O_SERDES word/valid.
interface serdes_tx_link_ctrl_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] tx_word;
  logic             tx_valid;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  tx_word,
    input  tx_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output tx_word,
    output tx_valid
  );
endinterface

// File: rtl/serdes_tx_link_ctrl.sv
// Fabric-side O_SERDES transmit controller: waits for PLL lock, trains the far
// end with a fixed pattern, then streams user words with idle fill.
module serdes_tx_link_ctrl #(
  parameter int               WIDTH         = 10,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = 10'b0000011111,
  parameter logic [WIDTH-1:0] IDLE_PATTERN  = 10'b0101010101,
  parameter int               LOCK_WAIT     = 255,
  parameter int               MIN_TRAIN     = 64
) (
  input  logic                        fabric_clk_div,
  input  logic                        reset_buf_n,
  input  logic                        pll_lock,
  input  logic                        enable,
  input  logic                        peer_ready,
  serdes_tx_link_ctrl_if.slave        bus,
  output logic                        link_up,
  output logic [1:0]                  state,
  output logic [15:0]                 word_count
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    TRAIN     = 2'd1,
    LINK      = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_WAIT - 1);
  localparam logic [7:0] TRAIN_MAX = 8'(MIN_TRAIN);

  state_t           cur_state;
  state_t           nxt_state;
  logic             lock_meta;
  logic             lock_s;
  logic             peer_meta;
  logic             peer_s;
  logic [7:0]       lock_cnt;
  logic [7:0]       lock_cnt_nxt;
  logic [7:0]       train_cnt;
  logic [7:0]       train_cnt_nxt;
  logic [WIDTH-1:0] tx_word_nxt;
  logic             tx_valid_nxt;
  logic [15:0]      word_count_nxt;
  logic             accept;

  // pll_lock and peer_ready come from other clock domains
  always_ff @(posedge fabric_clk_div or negedge reset_buf_n) begin
    if (!reset_buf_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      peer_meta <= 1'b0;
      peer_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
      peer_meta <= peer_ready;
      peer_s    <= peer_meta;
    end
  end

  assign bus.in_ready = (cur_state == LINK) && enable && peer_s;
  assign accept       = bus.in_valid && bus.in_ready;
  assign state        = cur_state;

  always_comb begin
    nxt_state      = cur_state;
    lock_cnt_nxt   = lock_cnt;
    train_cnt_nxt  = train_cnt;
    tx_word_nxt    = '0;
    tx_valid_nxt   = 1'b0;
    word_count_nxt = word_count;
    if (accept && (word_count != 16'hFFFF)) begin
      word_count_nxt = word_count + 16'd1;
    end
    // Loss of lock overrides everything, but an accept this cycle still counts
    if (!lock_s) begin
      nxt_state     = WAIT_LOCK;
      lock_cnt_nxt  = '0;
      train_cnt_nxt = '0;
    end else begin
      case (cur_state)
        WAIT_LOCK: begin
          if (lock_cnt == LOCK_LAST) begin
            nxt_state     = TRAIN;
            lock_cnt_nxt  = '0;
            train_cnt_nxt = '0;
          end else begin
            lock_cnt_nxt = lock_cnt + 8'd1;
          end
        end
        TRAIN: begin
          tx_word_nxt  = TRAIN_PATTERN;
          tx_valid_nxt = 1'b1;
          if ((train_cnt == TRAIN_MAX) && peer_s) begin
            nxt_state = LINK;
          end else if (train_cnt != TRAIN_MAX) begin
            train_cnt_nxt = train_cnt + 8'd1;
          end
        end
        LINK: begin
          tx_valid_nxt = 1'b1;
          tx_word_nxt  = accept ? bus.in_data : IDLE_PATTERN;
          if (!peer_s) begin
            nxt_state     = TRAIN;
            train_cnt_nxt = '0;
          end
        end
        default: begin
          nxt_state = WAIT_LOCK;
        end
      endcase
    end
  end

  always_ff @(posedge fabric_clk_div or negedge reset_buf_n) begin
    if (!reset_buf_n) begin
      cur_state    <= WAIT_LOCK;
      lock_cnt     <= '0;
      train_cnt    <= '0;
      bus.tx_word  <= '0;
      bus.tx_valid <= 1'b0;
      link_up      <= 1'b0;
      word_count   <= '0;
    end else begin
      cur_state    <= nxt_state;
      lock_cnt     <= lock_cnt_nxt;
      train_cnt    <= train_cnt_nxt;
      bus.tx_word  <= tx_word_nxt;
      bus.tx_valid <= tx_valid_nxt;
      link_up      <= (nxt_state == LINK);
      word_count   <= word_count_nxt;
    end
  end

endmodule

// File: tb/tb_serdes_tx_link_ctrl.sv
// Bench for serdes_tx_link_ctrl: a cycle reference model pushes expected
// registered outputs into a queue that a separate monitor pops and compares.
module tb_serdes_tx_link_ctrl;

  localparam int         WIDTH     = 10;
  localparam logic [9:0] TRAIN_PAT = 10'b0000011111;
  localparam logic [9:0] IDLE_PAT  = 10'b0101010101;
  localparam int         LOCK_WAIT = 255;
  localparam int         MIN_TRAIN = 64;

  typedef struct packed {
    logic [9:0]  word;
    logic        valid;
    logic [1:0]  st;
    logic        lu;
    logic [15:0] wc;
  } exp_t;

  logic        fabric_clk_div;
  logic        reset_buf_n;
  logic        pll_lock;
  logic        enable;
  logic        peer_ready;
  logic        link_up;
  logic [1:0]  state;
  logic [15:0] word_count;

  serdes_tx_link_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serdes_tx_link_ctrl dut (
    .fabric_clk_div (fabric_clk_div),
    .reset_buf_n    (reset_buf_n),
    .pll_lock       (pll_lock),
    .enable         (enable),
    .peer_ready     (peer_ready),
    .bus            (bus.slave),
    .link_up        (link_up),
    .state          (state),
    .word_count     (word_count)
  );

  initial fabric_clk_div = 1'b0;
  always #5 fabric_clk_div = ~fabric_clk_div;

  int   check_cnt = 0;
  int   pass_cnt  = 0;
  exp_t exp_q[$];

  // Reference model: phase 0 idle, 1 training, 2 linked; counts are plain ints
  int m_phase;
  int m_lock_run;
  int m_train_done;
  int m_wc;
  bit m_lock_pipe[2];
  bit m_peer_pipe[2];

  bit cur_lock;
  bit cur_en;
  bit cur_peer;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    m_phase        = 0;
    m_lock_run     = 0;
    m_train_done   = 0;
    m_wc           = 0;
    m_lock_pipe[0] = 1'b0;
    m_lock_pipe[1] = 1'b0;
    m_peer_pipe[0] = 1'b0;
    m_peer_pipe[1] = 1'b0;
  endfunction

  // Called at a falling edge; drives one cycle of inputs and returns at the next falling edge
  task automatic applyStimulus(input bit lock, input bit en, input bit peer,
                               input logic [9:0] data, input bit valid);
    exp_t e;
    bit   lock_seen;
    bit   peer_seen;
    bit   rdy;
    bit   acc;
    pll_lock     = lock;
    enable       = en;
    peer_ready   = peer;
    bus.in_data  = data;
    bus.in_valid = valid;
    lock_seen = m_lock_pipe[1];
    peer_seen = m_peer_pipe[1];
    rdy = (m_phase == 2) && en && peer_seen;
    acc = rdy && valid;
    if (acc && (m_wc < 65535)) m_wc++;
    e.word  = '0;
    e.valid = 1'b0;
    if (!lock_seen) begin
      m_phase      = 0;
      m_lock_run   = 0;
      m_train_done = 0;
    end else if (m_phase == 0) begin
      m_lock_run++;
      if (m_lock_run == LOCK_WAIT) begin
        m_phase      = 1;
        m_lock_run   = 0;
        m_train_done = 0;
      end
    end else if (m_phase == 1) begin
      e.word  = TRAIN_PAT;
      e.valid = 1'b1;
      if ((m_train_done >= MIN_TRAIN) && peer_seen) m_phase = 2;
      else m_train_done++;
    end else begin
      e.word  = acc ? data : IDLE_PAT;
      e.valid = 1'b1;
      if (!peer_seen) begin
        m_phase      = 1;
        m_train_done = 0;
      end
    end
    e.st = 2'(m_phase);
    e.lu = (m_phase == 2);
    e.wc = 16'(m_wc);
    m_lock_pipe[1] = m_lock_pipe[0];
    m_lock_pipe[0] = lock;
    m_peer_pipe[1] = m_peer_pipe[0];
    m_peer_pipe[0] = peer;
    exp_q.push_back(e);
    #1;
    checkOutput("in_ready", 32'(bus.in_ready), 32'(rdy));
    @(negedge fabric_clk_div);
  endtask

  task automatic runIdle();
    applyStimulus(cur_lock, cur_en, cur_peer, 10'h000, 1'b0);
  endtask

  // Monitor: every rising edge the DUT presents a new registered word
  always begin
    exp_t e;
    @(posedge fabric_clk_div);
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("sb_tx_word",    32'(bus.tx_word),  32'(e.word));
      checkOutput("sb_tx_valid",   32'(bus.tx_valid), 32'(e.valid));
      checkOutput("sb_state",      32'(state),        32'(e.st));
      checkOutput("sb_link_up",    32'(link_up),      32'(e.lu));
      checkOutput("sb_word_count", 32'(word_count),   32'(e.wc));
    end
  end

  initial begin
    int n;
    reset_buf_n  = 1'b0;
    pll_lock     = 1'b0;
    enable       = 1'b0;
    peer_ready   = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    modelReset();
    repeat (2) @(negedge fabric_clk_div);
    checkOutput("rst_tx_word",    32'(bus.tx_word),  32'd0);
    checkOutput("rst_tx_valid",   32'(bus.tx_valid), 32'd0);
    checkOutput("rst_in_ready",   32'(bus.in_ready), 32'd0);
    checkOutput("rst_link_up",    32'(link_up),      32'd0);
    checkOutput("rst_state",      32'(state),        32'd0);
    checkOutput("rst_word_count", 32'(word_count),   32'd0);

    reset_buf_n = 1'b1;
    cur_lock = 1'b1;
    cur_en   = 1'b1;
    cur_peer = 1'b1;
    n = 0;
    while ((state != 2'd1) && (n < 400)) begin
      runIdle();
      n++;
    end
    checkOutput("lock_wait_cycles", 32'(n), 32'(2 + LOCK_WAIT));

    runIdle();
    checkOutput("train_word",  32'(bus.tx_word),  32'(TRAIN_PAT));
    checkOutput("train_valid", 32'(bus.tx_valid), 32'd1);
    n = 1;
    while ((state == 2'd1) && (n < 200)) begin
      runIdle();
      n++;
    end
    checkOutput("train_cycles",  32'(n), 32'(MIN_TRAIN + 1));
    checkOutput("link_state",    32'(state),        32'd2);
    checkOutput("link_up",       32'(link_up),      32'd1);
    checkOutput("link_in_ready", 32'(bus.in_ready), 32'd1);

    applyStimulus(1'b1, 1'b1, 1'b1, 10'h2A5, 1'b1);
    checkOutput("data_word",  32'(bus.tx_word), 32'h2A5);
    checkOutput("data_count", 32'(word_count),  32'd1);
    runIdle();
    checkOutput("data_idle",  32'(bus.tx_word), 32'(IDLE_PAT));

    repeat (5) applyStimulus(1'b1, 1'b0, 1'b1, 10'($urandom), 1'b1);
    checkOutput("gate_count", 32'(word_count),  32'd1);
    checkOutput("gate_word",  32'(bus.tx_word), 32'(IDLE_PAT));

    cur_peer = 1'b0;
    repeat (2) runIdle();
    checkOutput("retrain_in_ready", 32'(bus.in_ready), 32'd0);
    runIdle();
    checkOutput("retrain_state", 32'(state), 32'd1);
    cur_peer = 1'b1;
    n = 0;
    while ((state == 2'd1) && (n < 200)) begin
      runIdle();
      n++;
    end
    checkOutput("retrain_cycles", 32'(n), 32'(MIN_TRAIN + 1));

    for (int i = 0; i < 1500; i++) begin
      if (cur_peer && ($urandom_range(63) == 0)) cur_peer = 1'b0;
      else if (!cur_peer && ($urandom_range(3) == 0)) cur_peer = 1'b1;
      applyStimulus(1'b1, $urandom_range(4) != 0, cur_peer, 10'($urandom), 1'($urandom));
    end
    cur_peer = 1'b1;
    n = 0;
    while ((state != 2'd2) && (n < 200)) begin
      runIdle();
      n++;
    end
    checkOutput("relink_state", 32'(state), 32'd2);

    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 10'($urandom), 1'b1);
    checkOutput("lockloss_state", 32'(state),        32'd0);
    checkOutput("lockloss_valid", 32'(bus.tx_valid), 32'd0);

    cur_lock = 1'b1;
    n = 0;
    while ((state != 2'd1) && (n < 400)) begin
      runIdle();
      n++;
    end
    checkOutput("relock_state", 32'(state), 32'd1);
    repeat (10) runIdle();

    reset_buf_n = 1'b0;
    #1;
    checkOutput("midrst_tx_word",    32'(bus.tx_word),  32'd0);
    checkOutput("midrst_tx_valid",   32'(bus.tx_valid), 32'd0);
    checkOutput("midrst_state",      32'(state),        32'd0);
    checkOutput("midrst_word_count", 32'(word_count),   32'd0);
    repeat (2) @(negedge fabric_clk_div);
    modelReset();
    reset_buf_n = 1'b1;
    repeat (300) runIdle();

    @(posedge fabric_clk_div);
    #3;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
